rega_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the 16-bit accumulator register A between several write sources (ALU result, memory load, immediate, I/O).
- Accepts one write per cycle over valid/ready handshakes.
- Drives the register's load strobe and data input from registered outputs.
- Sits between the execute/memory stages and register A; the control unit can stall all writes.

---
 rtl/rega_write_arbiter_if.sv | 39 +++
 rtl/rega_write_arbiter.sv | 123 ++++++++++++
 tb/tb_rega_write_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rega_write_arbiter_if.sv
// Write-request bus between the execute/memory stage requesters and the
// register-A write arbiter. Master = requesters side, slave = arbiter side.
interface rega_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  localparam int IW = $clog2(NREQ);

  // Handshake: requester i raises req_valid[i] with req_data slice i and holds
  // both until the cycle where req_valid[i] && req_ready[i]; that cycle is the
  // transfer. req_ready does not depend on itself and is at most one-hot.
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               loadA;
  logic [DW-1:0]      dataAin;
  logic [IW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  loadA,
    input  dataAin,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output loadA,
    output dataAin,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/rega_write_arbiter.sv
// Round-robin arbiter granting one write per cycle into accumulator register A.
// Optional macro REGA_WRCOUNT_EN adds a saturating transfer counter (wr_count).
module rega_write_arbiter #(
  parameter  int NREQ = 4,
  parameter  int DW   = 16,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
`ifdef REGA_WRCOUNT_EN
  input  logic                 wr_count_clr,
  output logic [15:0]          wr_count,
`endif
  rega_write_arbiter_if.slave  bus,
  output logic [IW-1:0]        dbg_ptr_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          load_q, load_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] gid_q, gid_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   scan_sum;
  logic [IW-1:0] scan_idx;
  logic          grant_ok;
  logic [NREQ-1:0] ready;
  logic [DW-1:0] sel_data;
  logic          xfer;

  // Priority scan starting at ptr_q, wrapping past NREQ-1 back to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IW+1)'(NREQ);
      end
      scan_idx = scan_sum[IW-1:0];
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Ready is held low during reset and stall so nothing transfers then.
  always_comb begin
    grant_ok = rst_n && !stall && win_found;
    ready    = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == win_idx) begin
        ready[i] = grant_ok;
        sel_data = bus.req_data[i*DW +: DW];
      end
    end
    xfer = |(bus.req_valid & ready);
  end

  always_comb begin
    load_d = xfer;
    data_d = data_q;
    gid_d  = gid_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      data_d = sel_data;
      gid_d  = win_idx;
      ptr_d  = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      load_q <= 1'b0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      load_q <= load_d;
      data_q <= data_d;
      gid_q  <= gid_d;
    end
  end

`ifdef REGA_WRCOUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_count_clr) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wr_count = cnt_q;
`endif

  assign bus.req_ready = ready;
  assign bus.loadA     = load_q;
  assign bus.dataAin   = data_q;
  assign bus.grant_id  = gid_q;
  assign bus.busy      = (|bus.req_valid) & ~xfer;
  assign dbg_ptr_o     = ptr_q;

endmodule

// File: tb/tb_rega_write_arbiter.sv
// Self-checking bench for rega_write_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_rega_write_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic [IW-1:0] dbg_ptr;
`ifdef REGA_WRCOUNT_EN
  logic        wr_count_clr = 1'b0;
  logic [15:0] wr_count;
`endif

  always #5 clk = ~clk;

  rega_write_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  rega_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
`ifdef REGA_WRCOUNT_EN
    .wr_count_clr (wr_count_clr),
    .wr_count     (wr_count),
`endif
    .bus          (bus.slave),
    .dbg_ptr_o    (dbg_ptr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int              m_ptr  = 0;
  logic            m_load = 1'b0;
  logic [DW-1:0]   m_data = '0;
  int              m_gid  = 0;
  int              m_cnt  = 0;
  int              exp_win;
  logic [NREQ-1:0] exp_ready;
  logic            exp_busy;
  logic [DW-1:0]   exp_q[$];

  task automatic set_data(input int i, input logic [DW-1:0] d);
    bus.req_data[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] get_data(input int i);
    return bus.req_data[i*DW +: DW];
  endfunction

  // Winner = first valid requester at or after the pointer, modulo NREQ.
  task automatic model_eval();
    exp_win   = -1;
    exp_ready = '0;
    if (rst_n && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        if (exp_win < 0 && bus.req_valid[(m_ptr + k) % NREQ]) exp_win = (m_ptr + k) % NREQ;
      end
    end
    if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
    exp_busy = (|bus.req_valid) && (exp_win < 0);
  endtask

  // Advance one clock; model tracks the edge, requester drops valid once accepted.
  task automatic tick();
    logic clr_now;
    model_eval();
`ifdef REGA_WRCOUNT_EN
    clr_now = wr_count_clr;
`else
    clr_now = 1'b0;
`endif
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_load = 1'b0; m_data = '0; m_gid = 0; m_cnt = 0;
    end else begin
      if (clr_now) m_cnt = 0;
      else if (exp_win >= 0 && m_cnt < 65535) m_cnt++;
      if (exp_win >= 0) begin
        m_load = 1'b1;
        m_data = get_data(exp_win);
        m_gid  = exp_win;
        m_ptr  = (exp_win + 1) % NREQ;
        exp_q.push_back(m_data);
      end else begin
        m_load = 1'b0;
      end
    end
    #1;
    if (exp_win >= 0) bus.req_valid[exp_win] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.req_data  = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
      else n_pass++;
      tick();
    end
    rst_n = 1'b1;
    bus.req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (bus.loadA !== 1'b0 || bus.dataAin !== 16'h0 || bus.grant_id !== 2'd0 || bus.req_ready !== 4'b0)
        $display("FAIL idle_outputs: got load=%b data=%h gid=%0d ready=%b expected 0/0000/0/0000",
                 bus.loadA, bus.dataAin, bus.grant_id, bus.req_ready);
      else n_pass++;
    end
`ifdef REGA_WRCOUNT_EN
    n_checks++;
    if (wr_count !== 16'h0) $display("FAIL reset_wr_count: got %h expected 0000", wr_count);
    else n_pass++;
`endif
  endtask

  task automatic test_single_write();
    bus.req_valid = 4'b0010;
    set_data(1, 16'h1234);
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", bus.req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.loadA !== 1'b1 || bus.dataAin !== 16'h1234 || bus.grant_id !== 2'd1)
      $display("FAIL single_load: got load=%b data=%h gid=%0d expected 1/1234/1", bus.loadA, bus.dataAin, bus.grant_id);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.loadA !== 1'b0 || bus.dataAin !== 16'h1234)
      $display("FAIL single_after: got load=%b data=%h expected 0/1234", bus.loadA, bus.dataAin);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_data(i, 16'hA000 + 16'(i));
    for (int k = 0; k < NREQ; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'(1 << k)) $display("FAIL rr_ready_%0d: got %b expected %b", k, bus.req_ready, 4'(1 << k));
      else n_pass++;
      tick();
      n_checks++;
      if (bus.loadA !== 1'b1 || bus.dataAin !== 16'hA000 + 16'(k) || bus.grant_id !== 2'(k))
        $display("FAIL rr_load_%0d: got load=%b data=%h gid=%0d expected 1/%h/%0d",
                 k, bus.loadA, bus.dataAin, bus.grant_id, 16'hA000 + 16'(k), k);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    bus.req_valid = 4'b1001;
    set_data(0, 16'h0C00);
    set_data(3, 16'h0C03);
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) $display("FAIL wrap_first: got %b expected 0001", bus.req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.grant_id !== 2'd0 || bus.dataAin !== 16'h0C00)
      $display("FAIL wrap_gid0: got gid=%0d data=%h expected 0/0c00", bus.grant_id, bus.dataAin);
    else n_pass++;
    n_checks++;
    if (bus.req_ready !== 4'b1000) $display("FAIL wrap_second: got %b expected 1000", bus.req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.grant_id !== 2'd3 || bus.dataAin !== 16'h0C03 || dbg_ptr !== 2'd0)
      $display("FAIL wrap_gid3: got gid=%0d data=%h ptr=%0d expected 3/0c03/0", bus.grant_id, bus.dataAin, dbg_ptr);
    else n_pass++;
  endtask

  task automatic test_stall();
    // A load issued just before the stall still appears.
    bus.req_valid = 4'b0001;
    set_data(0, 16'h1111);
    tick();
    stall = 1'b1;
    #1;
    n_checks++;
    if (bus.loadA !== 1'b1 || bus.dataAin !== 16'h1111)
      $display("FAIL stall_inflight: got load=%b data=%h expected 1/1111", bus.loadA, bus.dataAin);
    else n_pass++;
    bus.req_valid = 4'b0100;
    set_data(2, 16'h5A5A);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0 || bus.busy !== 1'b1)
        $display("FAIL stall_ready_%0d: got ready=%b busy=%b expected 0000/1", c, bus.req_ready, bus.busy);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.loadA !== 1'b0 || dbg_ptr !== 2'd1)
        $display("FAIL stall_hold_%0d: got load=%b ptr=%0d expected 0/1", c, bus.loadA, dbg_ptr);
      else n_pass++;
    end
    stall = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100 || bus.busy !== 1'b0)
      $display("FAIL stall_release: got ready=%b busy=%b expected 0100/0", bus.req_ready, bus.busy);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.loadA !== 1'b1 || bus.dataAin !== 16'h5A5A || bus.grant_id !== 2'd2)
      $display("FAIL stall_load: got load=%b data=%h gid=%0d expected 1/5a5a/2", bus.loadA, bus.dataAin, bus.grant_id);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 4'b0001;
    set_data(0, 16'hBEEF);
    tick();
    n_checks++;
    if (bus.loadA !== 1'b1 || bus.dataAin !== 16'hBEEF)
      $display("FAIL mid_accept: got load=%b data=%h expected 1/beef", bus.loadA, bus.dataAin);
    else n_pass++;
    rst_n = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0) $display("FAIL mid_ready: got %b expected 0000", bus.req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.loadA !== 1'b0 || dbg_ptr !== 2'd0 || bus.dataAin !== 16'h0 || bus.grant_id !== 2'd0)
      $display("FAIL mid_reset: got load=%b ptr=%0d data=%h gid=%0d expected 0/0/0000/0",
               bus.loadA, dbg_ptr, bus.dataAin, bus.grant_id);
    else n_pass++;
    rst_n = 1'b1;
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    int waits[NREQ];
    int max_wait = 0;
    int sb_err = 0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 9) < 4) begin
          bus.req_valid[i] = 1'b1;
          set_data(i, 16'($urandom));
        end
      end
      stall = ($urandom_range(0, 9) < 2);
      #1;
      model_eval();
      n_checks++;
      if (bus.req_ready !== exp_ready || bus.busy !== exp_busy)
        $display("FAIL rand_comb_%0d: got ready=%b busy=%b expected %b/%b", c, bus.req_ready, bus.busy, exp_ready, exp_busy);
      else n_pass++;
      if (exp_win >= 0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == exp_win) waits[i] = 0;
          else if (bus.req_valid[i]) waits[i]++;
          if (waits[i] > max_wait) max_wait = waits[i];
        end
      end
      tick();
      n_checks++;
      if (bus.loadA !== m_load || bus.dataAin !== m_data || int'(bus.grant_id) != m_gid || int'(dbg_ptr) != m_ptr)
        $display("FAIL rand_regs_%0d: got load=%b data=%h gid=%0d ptr=%0d expected %b/%h/%0d/%0d",
                 c, bus.loadA, bus.dataAin, bus.grant_id, dbg_ptr, m_load, m_data, m_gid, m_ptr);
      else n_pass++;
      if (bus.loadA === 1'b1) begin
        if (exp_q.size() == 0 || exp_q.pop_front() !== bus.dataAin) sb_err++;
      end
    end
    stall = 1'b0;
    n_checks++;
    if (sb_err != 0 || exp_q.size() != 0)
      $display("FAIL rand_scoreboard: got %0d errors %0d left expected 0/0", sb_err, exp_q.size());
    else n_pass++;
    n_checks++;
    if (max_wait > NREQ - 1) $display("FAIL rand_fairness: got max wait %0d expected <= %0d", max_wait, NREQ - 1);
    else n_pass++;
    bus.req_valid = '0;
    tick();
  endtask

`ifdef REGA_WRCOUNT_EN
  task automatic test_wr_count();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0001;
    wr_count_clr = 1'b1;
    tick();
    wr_count_clr = 1'b0;
    n_checks++;
    if (wr_count !== 16'h0) $display("FAIL cnt_clr_priority: got %h expected 0000", wr_count);
    else n_pass++;
    for (int c = 0; c < 70000; c++) begin
      bus.req_valid = 4'(1 << (c % NREQ));
      tick();
    end
    n_checks++;
    if (wr_count !== 16'hFFFF || m_cnt != 65535)
      $display("FAIL cnt_saturate: got %h expected ffff", wr_count);
    else n_pass++;
    bus.req_valid = '0;
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef REGA_WRCOUNT_EN
    test_wr_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
